// File: rtl/seq_mult_pkg.sv
// Shared state encoding and sizing constants for the sequential shift-add multiplier.
package seq_mult_pkg;

  localparam int WIDTH     = 32;
  localparam int CNT_W     = 5;
  localparam int LAST_ITER = 31;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/add_64bit.sv
// Combinational adder producing accumulator + shifted multiplicand for one iteration.
module add_64bit #(
  parameter int W = 2 * seq_mult_pkg::WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  // Carry out is dropped: the accumulator wraps modulo 2^W.
  assign sum = a + b;

endmodule

// File: rtl/seq_multiplier_32bit.sv
// Multi-cycle unsigned shift-add multiplier with start/done handshake.
// Define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_multiplier_32bit
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = seq_mult_pkg::WIDTH,
  parameter int CNT_W = seq_mult_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state_r;
  state_t               state_s;
  logic                 load_s;
  logic                 step_s;
  logic                 last_s;
  logic                 busy_r;
  logic                 done_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0]   sum_s;
  logic [WIDTH-1:0]     mult_r;
  logic [CNT_W-1:0]     cnt_r;

  add_64bit #(
    .W (2 * WIDTH)
  ) u_add (
    .a   (acc_r),
    .b   (mcand_r),
    .sum (sum_s)
  );

`ifdef SEQ_MULT_EARLY_TERM_EN
  // Stop once the post-shift multiplier has no set bits left.
  assign last_s = (cnt_r == LAST_CNT) || (mult_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
  assign last_s = (cnt_r == LAST_CNT);
`endif

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode plus load/iterate strobes for the datapath.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s = RUN;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Status flags registered from the next state so they align with state_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == RUN);
      done_r <= (state_s == DONE);
    end
  end

  // Operand capture and one shift-add iteration per RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r   <= {(2*WIDTH){1'b0}};
      mcand_r <= {(2*WIDTH){1'b0}};
      mult_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else if (load_s) begin
      acc_r   <= {(2*WIDTH){1'b0}};
      mcand_r <= {{WIDTH{1'b0}}, op_a};
      mult_r  <= op_b;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (step_s) begin
      if (mult_r[0]) begin
        acc_r <= sum_s;
      end else begin
        acc_r <= acc_r;
      end
      mcand_r <= mcand_r << 1;
      mult_r  <= mult_r >> 1;
      cnt_r   <= cnt_r + CNT_W'(1);
    end else begin
      acc_r   <= acc_r;
      mcand_r <= mcand_r;
      mult_r  <= mult_r;
      cnt_r   <= cnt_r;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign product_lo = acc_r[WIDTH-1:0];
  assign product_hi = acc_r[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// Self-checking bench for seq_multiplier_32bit against an arithmetic reference model.
module tb_seq_multiplier_32bit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] product_lo;
  logic [31:0] product_hi;

  int total;
  int bad;

  seq_multiplier_32bit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .product_lo (product_lo),
    .product_hi (product_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] a64;
    logic [63:0] b64;
    a64 = {32'd0, a};
    b64 = {32'd0, b};
    return a64 * b64;
  endfunction

  function automatic int ref_lat(input logic [31:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
    int m;
    m = 0;
    for (int i = 0; i < 32; i++) if (b[i]) m = i + 1;
    return (m < 1) ? 1 : m;
`else
    return 32;
`endif
  endfunction

  // Accept one operation and count cycles (bounded) until done is seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op_a = 32'd0; op_b = 32'd0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if ({product_hi, product_lo} !== 64'd0) begin
      bad++; $display("FAIL reset_product got=%h want=0", {product_hi, product_lo});
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] a;
    int lat;
    int done_cnt;
    a = $urandom | 32'd1;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrun_busy got=%b want=1", busy); end
    total++; if ({product_hi, product_lo} !== ref_prod(a, 32'h0000_03FF)) begin
      bad++; $display("FAIL midrun_partial got=%h want=%h", {product_hi, product_lo}, ref_prod(a, 32'h0000_03FF));
    end
    #2 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL async_reset_flags got busy=%b done=%b want 0/0", busy, done);
    end
    total++; if ({product_hi, product_lo} !== 64'd0) begin
      bad++; $display("FAIL async_reset_product got=%h want=0", {product_hi, product_lo});
    end
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL no_done_after_reset got=%0d want=0", done_cnt); end
    run_op(32'd11, 32'd13, lat);
    total++; if ({product_hi, product_lo} !== 64'd143 || lat != ref_lat(32'd13)) begin
      bad++; $display("FAIL post_reset_op got prod=%h lat=%0d want prod=%h lat=%0d",
                      {product_hi, product_lo}, lat, 64'd143, ref_lat(32'd13));
    end
  endtask

  task automatic test_directed;
    logic [31:0] a_tab [3];
    logic [31:0] b_tab [3];
    int lat;
    a_tab[0] = 32'd7;         b_tab[0] = 32'd6;
    a_tab[1] = 32'hFFFF_FFFF; b_tab[1] = 32'hFFFF_FFFF;
    a_tab[2] = 32'h1234_5678; b_tab[2] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      run_op(a_tab[i], b_tab[i], lat);
      total++; if ({product_hi, product_lo} !== ref_prod(a_tab[i], b_tab[i])) begin
        bad++; $display("FAIL directed_prod[%0d] got=%h want=%h", i, {product_hi, product_lo}, ref_prod(a_tab[i], b_tab[i]));
      end
      total++; if (lat != ref_lat(b_tab[i])) begin
        bad++; $display("FAIL directed_lat[%0d] got=%0d want=%0d", i, lat, ref_lat(b_tab[i]));
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL directed_busy_at_done[%0d] got=%b want=0", i, busy); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL directed_done_one_cycle[%0d] got=%b want=0", i, done); end
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    int exp_lat;
    int pulse_at;
    exp_lat  = ref_lat(32'd3);
    pulse_at = (exp_lat > 4) ? 4 : exp_lat - 1;
    @(negedge clk);
    start = 1'b1; op_a = 32'd5; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == pulse_at) begin
        start = 1'b1; op_a = 32'd9; op_b = 32'd9;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    total++; if ({product_hi, product_lo} !== 64'd15) begin
      bad++; $display("FAIL ignore_start_prod got=%h want=%h", {product_hi, product_lo}, 64'd15);
    end
    total++; if (lat != exp_lat) begin bad++; $display("FAIL ignore_start_lat got=%0d want=%0d", lat, exp_lat); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL ignore_start_idle got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(32'd5, 32'd3, lat);
    total++; if (done !== 1'b1 || {product_hi, product_lo} !== 64'd15) begin
      bad++; $display("FAIL b2b_first got done=%b prod=%h want 1/%h", done, {product_hi, product_lo}, 64'd15);
    end
    start = 1'b1; op_a = 32'd100; op_b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_rebusy got busy=%b done=%b want 1/0", busy, done);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++; if ({product_hi, product_lo} !== 64'd200 || lat != ref_lat(32'd2)) begin
      bad++; $display("FAIL b2b_second got prod=%h lat=%0d want %h/%0d", {product_hi, product_lo}, lat, 64'd200, ref_lat(32'd2));
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [31:0] b;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      run_op(a, b, lat);
      total++; if ({product_hi, product_lo} !== ref_prod(a, b) || lat != ref_lat(b)) begin
        bad++; $display("FAIL random[%0d] a=%h b=%h got prod=%h lat=%0d want prod=%h lat=%0d",
                        i, a, b, {product_hi, product_lo}, lat, ref_prod(a, b), ref_lat(b));
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_directed;
    test_reset_mid_run;
    test_ignore_start;
    test_back_to_back;
    test_random;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_multiplier_32bit.md
Name: seq_multiplier_32bit

Overview:
Multi-cycle unsigned shift-add multiplier for the processor datapath. It produces a 64-bit product of two 32-bit operands. product_lo feeds the multiply input of the ALU result-select mux; product_hi is kept for a future MFHI-style path. It sits upstream of the result mux and is started by the control unit with a start/done handshake.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH bits.
CNT_W, 5, iteration counter width; must equal log2(WIDTH).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only while busy=0
op_a  input  WIDTH  multiplicand; captured on the accepted start edge
op_b  input  WIDTH  multiplier; captured on the accepted start edge
busy  output  1  high in RUN state
done  output  1  one-cycle pulse; product valid
product_lo  output  WIDTH  low half of the product, to the result mux
product_hi  output  WIDTH  high half of the product

Behaviour:
- Reset: clk is the only clock. reset is asynchronous and active-high. It forces state=IDLE, busy=0, done=0, product_lo=0, product_hi=0, and clears all internal registers. Reset mid-operation abandons the computation and emits no done.
- States:
  - IDLE and DONE: busy=0.
  - RUN: busy=1.
  - DONE lasts exactly one cycle; done=1 only in DONE.
- Accept: start=1 at a rising edge while in IDLE or DONE. On that edge:
  - mcand (2*WIDTH bits) loads zero-extended op_a.
  - mult loads op_b.
  - The accumulator {product_hi, product_lo} clears to 0.
  - cnt clears to 0.
  - Next state is RUN.
  - start in DONE is accepted, so back-to-back operation has no idle gap.
- start while busy=1 is ignored. Operands are not re-sampled and the operation in flight is unaffected.
- Each RUN edge performs one iteration:
  - If mult[0]=1, accumulator += mcand, modulo 2^(2*WIDTH).
  - mcand <<= 1; mult >>= 1 (logical); cnt += 1.
  - Next state is DONE when cnt==WIDTH-1 before the increment; otherwise RUN.
- Latency: call the accepting edge E0. Iterations occur on edges E1..E32. done is high during the cycle after E32, i.e. 32 cycles after acceptance.
- Product hold: the accumulator is visible on product_hi/product_lo at all times. It is guaranteed final while done=1 and holds until the next accepted start clears it.
- No overflow indication; the 64-bit result is always exact.
- DONE with no start goes to IDLE on the next edge.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined: in RUN, next state is also DONE when the post-shift mult value is 0. The iteration on that edge still completes first. Latency becomes max(1, index of highest set bit of op_b + 1) cycles.
- Undefined: fixed 32-cycle latency.
- Results are identical in both builds.

Decomposition:
- Package seq_mult_pkg holds:
  - state encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - constants WIDTH=32, CNT_W=5, LAST_ITER=31.
- One sub-module, add_64bit: a combinational 64-bit adder for accumulator + mcand, instantiated once.
- Control FSM and datapath registers stay in seq_multiplier_32bit.

Test Plan:
1. Reset with reset=1 mid-RUN (cycle 10 of 32) -> busy=0, done=0, product_hi/product_lo=0 immediately (asynchronous). No done pulse follows; the next start completes normally.
2. op_a=7, op_b=6 -> product_lo=42, product_hi=0.
   - Early-term undefined: done 32 cycles after acceptance.
   - Early-term defined: done 3 cycles after acceptance.
3. op_a=op_b=0xFFFFFFFF -> product_hi=0xFFFFFFFE, product_lo=0x00000001; done after 32 cycles in both builds.
4. Start 5x3, then pulse start with op_a=9, op_b=9 at cycle 4 of RUN -> the pulse is ignored; result is 15, not 81.
5. Start 5x3; in the DONE cycle assert start with 100x2 -> done pulses once with 15 visible; busy re-asserts next edge; the second done shows 200.
6. op_b=0, op_a=0x12345678 -> product 0.
   - Early-term defined: done 1 cycle after acceptance.
   - Early-term undefined: done after 32 cycles.
